// File: rtl/msp430_noc_pkg.sv
// Shared constants for the MSP430 tile NoC interface: default flit width and
// default buffer depth used by the NoC buffer and its storage.
package msp430_noc_pkg;

  localparam int unsigned NOC_FLIT_WIDTH   = 32;
  localparam int unsigned NOC_BUFFER_DEPTH = 4;

endpackage : msp430_noc_pkg

// File: rtl/msp430_noc_buffer_mem.sv
// DEPTH x (FLIT_WIDTH+1) flit storage for the NoC buffer: one synchronous
// write port, one asynchronous read port. Entry layout is {last, flit}.
module msp430_noc_buffer_mem
  import msp430_noc_pkg::*;
#(
  parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
  parameter int DEPTH      = NOC_BUFFER_DEPTH
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [FLIT_WIDTH:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [FLIT_WIDTH:0]        rd_data
);

  logic [FLIT_WIDTH:0] mem [DEPTH];

  // NOTE: storage has no reset; validity comes from the pointers and
  // occupancy in the controller, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : msp430_noc_buffer_mem

// File: rtl/msp430_noc_buffer.sv
// Flit buffer between an MSP430 tile NoC port and a mesh router input.
// Cut-through by default; define MSP430_NOC_BUFFER_STORE_FORWARD_EN for store-and-forward.
module msp430_noc_buffer
  import msp430_noc_pkg::*;
#(
  parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
  parameter int DEPTH      = NOC_BUFFER_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLIT_WIDTH-1:0]        in_flit,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [FLIT_WIDTH-1:0]        out_flit,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       occ_q;
  logic                ready_en_q;
  logic                push;
  logic                pop;
  logic [FLIT_WIDTH:0] rd_data;

  // ready_en_q keeps in_ready low through reset and raises it on the first edge after release.
  assign in_ready  = ready_en_q && (occ_q != FULL_COUNT);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = occ_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef MSP430_NOC_BUFFER_STORE_FORWARD_EN
  // Count of complete packets held; a full buffer releases its head anyway so
  // packets longer than DEPTH cannot deadlock.
  logic [CW-1:0] pkt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_q <= '0;
    end else begin
      case ({push && in_last, pop && out_last})
        2'b10:   pkt_q <= pkt_q + CW'(1);
        2'b01:   pkt_q <= pkt_q - CW'(1);
        default: pkt_q <= pkt_q;
      endcase
    end
  end

  assign out_valid = (occ_q != '0) && ((pkt_q != '0) || (occ_q == FULL_COUNT));
`else
  assign out_valid = (occ_q != '0);
`endif

  msp430_noc_buffer_mem #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({in_last, in_flit}),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign {out_last, out_flit} = rd_data;

endmodule : msp430_noc_buffer
